shape_read: RTL
===============

Name: shape_read

Overview:
- Read-side counterpart of the shape-record writer. Fetches one shape record (ty, x, y, size, rotate) from shape RAM on a trigger pulse and presents the fields as registered outputs.
- Record base address is (id << DATAB) + ram_address_offset. Each record occupies 2^DATAB words.
- Sits between the shape RAM read port and the renderer/collision logic. Field outputs update atomically, only when a read completes.

Parameters:
- DATAB, 3: log2 of words per record (8).
- CORDW, 10: coordinate width of x and y.
- ADDRW, 20: RAM address width.
- DATAW, 12: RAM word width.
- NUMW, DATAW: width of shape id.
- RD_LAT, 1: RAM read latency in cycles, from address/enable to valid ram_data. Legal range 1..4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id  in  NUMW  shape index; sampled on accepted trigger
- trigger  in  1  start a record read; honoured only when idle
- ram_address_offset  in  ADDRW  table base; sampled on accepted trigger
- ram_address  out  ADDRW  read address
- ram_rd_enable  out  1  read strobe
- ram_data  in  DATAW  read data, valid RD_LAT cycles after its address
- busy  out  1  high while a read is in progress
- done  out  1  one-cycle pulse; field outputs updated this cycle
- ty  out  DATAW  shape type (word 0)
- x  out  CORDW  x coordinate (word 1, bits CORDW-1:0)
- y  out  CORDW  y coordinate (word 2, bits CORDW-1:0)
- size  out  DATAW  size (word 3)
- rotate  out  DATAW  rotation (word 4)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and overrides everything.
- Reset values: state IDLE; busy, done, ram_rd_enable all 0; ty, x, y, size, rotate all 0; ram_address 0; capture pipeline valid bits cleared.
- Record layout: words 0..4 hold ty, x, y, size, rotate. Words 5..2^DATAB-1 are reserved and never read.
- States:
  - IDLE: on trigger, latch base = ((id << DATAB) + ram_address_offset) mod 2^ADDRW, set ptr = 0, go to ISSUE.
  - ISSUE: ram_rd_enable = 1 and ram_address = base + ptr (mod 2^ADDRW). ptr advances 0..4, one address per cycle. After ptr = 4, go to DRAIN.
  - DRAIN: lasts exactly RD_LAT cycles, then go to IDLE. On that transition, copy the shadow fields to the outputs and pulse done for one cycle.
- Capture pipeline: a RD_LAT-deep delay line of {valid, ptr}. When the delayed valid is set, ram_data is written into the shadow field selected by the delayed ptr. x and y take only ram_data[CORDW-1:0]; upper bits are discarded.
- Atomicity: ty/x/y/size/rotate change only on the edge that raises done. They hold their previous values for the whole duration of a read.
- Timing (trigger sampled at the end of cycle 0):
  - busy = 1 in cycles 1..5+RD_LAT.
  - ram_rd_enable = 1 in cycles 1..5 only.
  - done = 1 and new outputs visible in cycle 6+RD_LAT, with busy = 0 in that cycle.
- Trigger handling:
  - trigger while busy is ignored; it is not queued.
  - trigger in the done cycle is accepted, giving back-to-back reads.
  - id and offset changes after acceptance have no effect on the read in progress.
- Outside ISSUE: ram_rd_enable = 0 and ram_address holds its last value.
- Reset mid-read: the read aborts and outputs return to 0. No done pulse is produced, and late RAM data arriving after reset is discarded.
- Address wrap: all address arithmetic is modulo 2^ADDRW with no error indication.

Test Plan:
- RD_LAT=1, offset=0, id=2, RAM[16..20]={3,0x1A5,0x0F0,40,90} -> ram_address 16..20 in cycles 1..5; ram_rd_enable high exactly 5 cycles; done in cycle 7; outputs ty=3, x=0x1A5, y=0x0F0, size=40, rotate=90.
- offset=0x100, id=5, RAM[0x129]=0xFA5 -> addresses 0x128..0x12C; x=0x3A5 (truncated to CORDW bits).
- offset=0xFFFFC, id=0 -> addresses 0xFFFFC, 0xFFFFD, 0xFFFFE, 0xFFFFF, 0x00000 (wrap); fields read correctly.
- trigger held high continuously -> second read starts in the done cycle; a separate trigger pulse in cycle 3 does not restart the read; outputs keep the first record until the second done.
- RD_LAT=3 -> busy for cycles 1..8, done in cycle 9, correct field mapping despite the deeper pipeline.
- rst asserted in cycle 3 of a read that follows a completed read -> in cycle 4 busy, done and ram_rd_enable are 0 and all fields are 0; no done pulse follows.

Source files
------------

// File: rtl/shape_read.sv
// shape_read: fetches one five-word shape record (ty, x, y, size, rotate)
// from shape RAM and presents the fields as registered outputs.
// Handshake: trigger is a request that is accepted only in IDLE (including the
// done cycle). There is no back-pressure: a trigger seen while busy is dropped.
// done is a one-cycle strobe marking the cycle in which the new fields appear.
module shape_read #(
  parameter int DATAB  = 3,
  parameter int CORDW  = 10,
  parameter int ADDRW  = 20,
  parameter int DATAW  = 12,
  parameter int NUMW   = DATAW,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUMW-1:0]  id,
  input  logic             trigger,
  input  logic [ADDRW-1:0] ram_address_offset,
  output logic [ADDRW-1:0] ram_address,
  output logic             ram_rd_enable,
  input  logic [DATAW-1:0] ram_data,
  output logic             busy,
  output logic             done,
  output logic [DATAW-1:0] ty,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic [DATAW-1:0] size,
  output logic [DATAW-1:0] rotate,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_e;

  localparam logic [2:0] LAST_PTR   = 3'd4;
  localparam logic [2:0] LAST_DRAIN = 3'(RD_LAT - 1);

  state_e           state_q;
  logic [2:0]       ptr_q;
  logic [2:0]       drain_q;
  logic [RD_LAT-1:0] pv_q;
  logic [2:0]       pp_q [RD_LAT];

  logic [DATAW-1:0] sh_ty_q, sh_ty_d;
  logic [CORDW-1:0] sh_x_q, sh_x_d;
  logic [CORDW-1:0] sh_y_q, sh_y_d;
  logic [DATAW-1:0] sh_size_q, sh_size_d;
  logic [DATAW-1:0] sh_rot_q, sh_rot_d;

  logic [ADDRW-1:0] base_new;

  // Record base: id scaled by record size plus table offset, wrapping silently.
  assign base_new  = (ADDRW'(id) << DATAB) + ram_address_offset;
  assign state_dbg = state_q;

  // Route the word leaving the capture pipeline into its shadow field.
  always_comb begin
    sh_ty_d   = sh_ty_q;
    sh_x_d    = sh_x_q;
    sh_y_d    = sh_y_q;
    sh_size_d = sh_size_q;
    sh_rot_d  = sh_rot_q;
    if (pv_q[RD_LAT-1]) begin
      case (pp_q[RD_LAT-1])
        3'd0:    sh_ty_d   = ram_data;
        3'd1:    sh_x_d    = ram_data[CORDW-1:0];
        3'd2:    sh_y_d    = ram_data[CORDW-1:0];
        3'd3:    sh_size_d = ram_data;
        3'd4:    sh_rot_d  = ram_data;
        default: ;
      endcase
    end
  end

  // Capture pipeline: delays {valid, ptr} by RD_LAT to line up with ram_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pp_q[i] <= '0;
      sh_ty_q   <= '0;
      sh_x_q    <= '0;
      sh_y_q    <= '0;
      sh_size_q <= '0;
      sh_rot_q  <= '0;
    end else begin
      pv_q[0] <= ram_rd_enable;
      pp_q[0] <= ptr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pp_q[i] <= pp_q[i-1];
      end
      sh_ty_q   <= sh_ty_d;
      sh_x_q    <= sh_x_d;
      sh_y_q    <= sh_y_d;
      sh_size_q <= sh_size_d;
      sh_rot_q  <= sh_rot_d;
    end
  end

  // Control FSM: issue five addresses, wait out the read latency, then publish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      drain_q       <= '0;
      ram_address   <= '0;
      ram_rd_enable <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ty            <= '0;
      x             <= '0;
      y             <= '0;
      size          <= '0;
      rotate        <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger) begin
            ram_address   <= base_new;
            ram_rd_enable <= 1'b1;
            busy          <= 1'b1;
            ptr_q         <= '0;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (ptr_q == LAST_PTR) begin
            ram_rd_enable <= 1'b0;
            drain_q       <= '0;
            state_q       <= DRAIN;
          end else begin
            ptr_q       <= ptr_q + 3'd1;
            ram_address <= ram_address + ADDRW'(1);
          end
        end
        DRAIN: begin
          if (drain_q == LAST_DRAIN) begin
            // The last word lands in the shadow on this same edge, so publish
            // from the shadow's next value.
            ty      <= sh_ty_d;
            x       <= sh_x_d;
            y       <= sh_y_d;
            size    <= sh_size_d;
            rotate  <= sh_rot_d;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
